// File: rtl/baccarat_ctrl.sv
// Baccarat hand sequencer: deals four cards, applies natural/player/banker draw rules, latches win lights.
// Optional full banker tableau in EVAL6 when BACCARAT_TABLEAU_EN is defined; otherwise dscore<=5 draws.
module baccarat_ctrl #(
  parameter int unsigned DONE_HOLD = 0
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic [3:0] pcard3,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       hand_done
);

  // state     | meaning
  // DEAL_P1   | load player card 1
  // DEAL_D1   | load dealer card 1
  // DEAL_P2   | load player card 2
  // DEAL_D2   | load dealer card 2
  // EVAL4     | natural / player third-card decision
  // DEAL_P3   | load player card 3
  // EVAL6     | banker third-card decision
  // DEAL_D3   | load dealer card 3
  // DONE      | hand finished, lights valid
  typedef enum logic [3:0] {
    S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2, S_EVAL4,
    S_DEAL_P3, S_EVAL6, S_DEAL_D3, S_DONE
  } state_t;

  localparam logic [15:0] HOLD_INIT = (DONE_HOLD > 0) ? 16'(DONE_HOLD - 1) : 16'd0;

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [5:0]  strobe_q, strobe_d;
  logic        pwin_q, pwin_d;
  logic        dwin_q, dwin_d;
  logic        done_q, done_d;

  logic [3:0]  p_sat, d_sat;
  logic        banker_draw;

  assign p_sat = (pscore > 4'd9) ? 4'd9 : pscore;
  assign d_sat = (dscore > 4'd9) ? 4'd9 : dscore;

`ifdef BACCARAT_TABLEAU_EN
  logic [3:0] v3;
  assign v3 = (pcard3 > 4'd9) ? 4'd0 : pcard3;

  always_comb begin
    banker_draw = 1'b0;
    case (d_sat)
      4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
      4'd3:             banker_draw = (v3 != 4'd8);
      4'd4:             banker_draw = (v3 >= 4'd2) && (v3 <= 4'd7);
      4'd5:             banker_draw = (v3 >= 4'd4) && (v3 <= 4'd7);
      4'd6:             banker_draw = (v3 >= 4'd6) && (v3 <= 4'd7);
      default:          banker_draw = 1'b0;
    endcase
  end
`else
  logic unused_pcard3;
  assign unused_pcard3 = ^pcard3;
  assign banker_draw   = (d_sat <= 4'd5);
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_DEAL_P1: state_d = S_DEAL_D1;
      S_DEAL_D1: state_d = S_DEAL_P2;
      S_DEAL_P2: state_d = S_DEAL_D2;
      S_DEAL_D2: state_d = S_EVAL4;
      S_EVAL4: begin
        if ((p_sat >= 4'd8) || (d_sat >= 4'd8)) state_d = S_DONE;
        else if (p_sat <= 4'd5)                 state_d = S_DEAL_P3;
        else if (d_sat <= 4'd5)                 state_d = S_DEAL_D3;
        else                                    state_d = S_DONE;
      end
      S_DEAL_P3: state_d = S_EVAL6;
      S_EVAL6:   state_d = banker_draw ? S_DEAL_D3 : S_DONE;
      S_DEAL_D3: state_d = S_DONE;
      S_DONE: begin
        if (DONE_HOLD != 0) begin
          if (hold_q == 16'd0) state_d = S_DEAL_P1;
          else                 hold_d  = hold_q - 16'd1;
        end
      end
      default:   state_d = S_DEAL_P1;
    endcase
    // hold timer is a down-counter armed on entry to DONE
    if ((state_d == S_DONE) && (state_q != S_DONE)) hold_d = HOLD_INIT;
  end

  // Outputs are registered one cycle behind the state so reset leaves everything at 0.
  always_comb begin
    strobe_d = 6'b000000;
    case (state_q)
      S_DEAL_P1: strobe_d = 6'b100000;
      S_DEAL_D1: strobe_d = 6'b010000;
      S_DEAL_P2: strobe_d = 6'b001000;
      S_DEAL_D2: strobe_d = 6'b000100;
      S_DEAL_P3: strobe_d = 6'b000010;
      S_DEAL_D3: strobe_d = 6'b000001;
      default:   strobe_d = 6'b000000;
    endcase
    done_d = (state_q == S_DONE);
    pwin_d = pwin_q;
    dwin_d = dwin_q;
    if (state_q != S_DONE) begin
      pwin_d = 1'b0;
      dwin_d = 1'b0;
    end else if (!done_q) begin
      pwin_d = (p_sat >= d_sat);
      dwin_d = (d_sat >= p_sat);
    end
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q  <= S_DEAL_P1;
      hold_q   <= 16'd0;
      strobe_q <= 6'b000000;
      pwin_q   <= 1'b0;
      dwin_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      strobe_q <= strobe_d;
      pwin_q   <= pwin_d;
      dwin_q   <= dwin_d;
      done_q   <= done_d;
    end
  end

  assign load_pcard1      = strobe_q[5];
  assign load_dcard1      = strobe_q[4];
  assign load_pcard2      = strobe_q[3];
  assign load_dcard2      = strobe_q[2];
  assign load_pcard3      = strobe_q[1];
  assign load_dcard3      = strobe_q[0];
  assign player_win_light = pwin_q;
  assign dealer_win_light = dwin_q;
  assign hand_done        = done_q;

endmodule
